// File: rtl/aes_kexp_pkg.sv
// ============================================================================
// Module      : aes_kexp_pkg
// Description : Shared types, constants and GF(2^8) helpers for the AES-128
//               key-expansion controller.
// Config      : AES_KEXP_SHARED_SBOX_EN (selects the shared-sbox subWord)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_kexp_pkg;

  localparam int         AES_KEY_W         = 128;
  localparam int         AES_WORD_W        = 32;
  localparam int         AES128_MAX_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT         = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_EXPAND  = 2'd2
  } kexp_state_t;

  // Multiply by x in GF(2^8) with the AES polynomial; also the rcon step.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Rotate a word left by one byte: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Algebraic sbox: multiplicative inverse (x^254, zero maps to zero)
  // followed by the AES affine transform.
  function automatic logic [7:0] sbox_fn(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_kexp_sub_seq.sv
// ============================================================================
// Module      : aes_kexp_sub_seq
// Description : subWord sequencer behind a start/done interface. Baseline is
//               four parallel sboxes (done in the start cycle); with
//               AES_KEXP_SHARED_SBOX_EN one sbox walks the bytes MSB first
//               over four cycles and done is raised on the fourth.
// Config      : AES_KEXP_SHARED_SBOX_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_kexp_sub_seq
  import aes_kexp_pkg::*;
(
`ifdef AES_KEXP_SHARED_SBOX_EN
  input  logic                  clk,
  input  logic                  rst,      // asynchronous, active low
`endif
  input  logic                  i_start,  // held high until o_done
  input  logic [AES_WORD_W-1:0] i_word,   // must stay stable while i_start
  output logic                  o_done,
  output logic [AES_WORD_W-1:0] o_word
);

`ifdef AES_KEXP_SHARED_SBOX_EN
  logic [1:0]  r_k;
  logic [23:0] r_tmp;
  logic [7:0]  w_sel;
  logic [7:0]  w_sub;

  // Select byte k of the input word, most significant first.
  always_comb begin
    w_sel = i_word[31:24];
    case (r_k)
      2'd0:    w_sel = i_word[31:24];
      2'd1:    w_sel = i_word[23:16];
      2'd2:    w_sel = i_word[15:8];
      default: w_sel = i_word[7:0];
    endcase
  end

  aes_sbox u_sbox (
    .i_byte(w_sel),
    .o_byte(w_sub)
  );

  // Capture the upper three bytes; the last byte goes straight to o_word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k   <= 2'd0;
      r_tmp <= 24'h0;
    end else if (i_start) begin
      r_k <= r_k + 2'd1;
      case (r_k)
        2'd0:    r_tmp[23:16] <= w_sub;
        2'd1:    r_tmp[15:8]  <= w_sub;
        2'd2:    r_tmp[7:0]   <= w_sub;
        default: r_tmp        <= r_tmp;
      endcase
    end
  end

  assign o_done = i_start && (r_k == 2'd3);
  assign o_word = {r_tmp, w_sub};
`else
  aes_subword u_subword (
    .i_word(i_word),
    .o_word(o_word)
  );

  assign o_done = i_start;
`endif

endmodule

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module      : aes_sbox / aes_subword
// Description : Combinational AES sbox and the 4-byte subWord built from it.
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox
  import aes_kexp_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = sbox_fn(i_byte);

endmodule

module aes_subword
  import aes_kexp_pkg::*;
(
  input  logic [AES_WORD_W-1:0] i_word,
  output logic [AES_WORD_W-1:0] o_word
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    aes_sbox u_sbox (
      .i_byte(i_word[8*g +: 8]),
      .o_byte(o_word[8*g +: 8])
    );
  end

endmodule

`default_nettype wire

// File: rtl/aes_key_expand_ctrl.sv
// ============================================================================
// Module      : aes_key_expand_ctrl
// Description : Sequential AES-128 key expansion. Emits round keys
//               0..NUM_ROUNDS over a valid/ready stream, expanding one word
//               per cycle in place between handshakes.
// Config      : AES_KEXP_SHARED_SBOX_EN (single time-multiplexed sbox)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_expand_ctrl
  import aes_kexp_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active low
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic [3:0]           rk_round,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic                 busy
);

  // Out-of-range parameters are clamped to the legal 1..10 window.
  localparam int c_LAST_INT = (NUM_ROUNDS > AES128_MAX_ROUNDS) ? AES128_MAX_ROUNDS :
                              (NUM_ROUNDS < 1) ? 1 : NUM_ROUNDS;
  localparam logic [3:0] c_LAST_ROUND = 4'(c_LAST_INT);

  kexp_state_t          r_state, w_state_nxt;
  logic [AES_KEY_W-1:0] r_rk, w_rk_nxt;
  logic [3:0]           r_round, w_round_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [7:0]           r_rcon, w_rcon_nxt;
  logic [1:0]           r_j, w_j_nxt;
  logic                 w_sub_start;
  logic                 w_sub_done;
  logic [AES_WORD_W-1:0] w_sub_word;
  logic [AES_WORD_W-1:0] w_rot;

  assign w_rot = rot_word(r_rk[31:0]);

  aes_kexp_sub_seq u_sub_seq (
`ifdef AES_KEXP_SHARED_SBOX_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .i_start(w_sub_start),
    .i_word (w_rot),
    .o_done (w_sub_done),
    .o_word (w_sub_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Round-key, round index, valid, rcon and word-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rk    <= '0;
      r_round <= 4'd0;
      r_valid <= 1'b0;
      r_rcon  <= RCON_INIT;
      r_j     <= 2'd0;
    end else begin
      r_rk    <= w_rk_nxt;
      r_round <= w_round_nxt;
      r_valid <= w_valid_nxt;
      r_rcon  <= w_rcon_nxt;
      r_j     <= w_j_nxt;
    end
  end

  // Next-state and datapath update; w0 waits on the subWord sequencer,
  // w1..w3 each take one cycle and chain off the freshly written word.
  always_comb begin
    w_state_nxt = r_state;
    w_rk_nxt    = r_rk;
    w_round_nxt = r_round;
    w_valid_nxt = r_valid;
    w_rcon_nxt  = r_rcon;
    w_j_nxt     = r_j;
    w_sub_start = 1'b0;
    key_ready   = (r_state == ST_IDLE);
    busy        = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (key_valid) begin
          w_rk_nxt    = key_in;
          w_round_nxt = 4'd0;
          w_rcon_nxt  = RCON_INIT;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (rk_ready) begin
          w_valid_nxt = 1'b0;
          if (r_round == c_LAST_ROUND) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_j_nxt     = 2'd0;
            w_state_nxt = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        case (r_j)
          2'd0: begin
            w_sub_start = 1'b1;
            if (w_sub_done) begin
              w_rk_nxt[127:96] = r_rk[127:96] ^ w_sub_word ^ {r_rcon, 24'h0};
              w_j_nxt          = 2'd1;
            end
          end
          2'd1: begin
            w_rk_nxt[95:64] = r_rk[95:64] ^ r_rk[127:96];
            w_j_nxt         = 2'd2;
          end
          2'd2: begin
            w_rk_nxt[63:32] = r_rk[63:32] ^ r_rk[95:64];
            w_j_nxt         = 2'd3;
          end
          default: begin
            w_rk_nxt[31:0] = r_rk[31:0] ^ r_rk[63:32];
            w_j_nxt        = 2'd0;
            w_round_nxt    = r_round + 4'd1;
            w_rcon_nxt     = xtime(r_rcon);
            w_valid_nxt    = 1'b1;
            w_state_nxt    = ST_PRESENT;
          end
        endcase
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign rk_out   = r_rk;
  assign rk_round = r_round;
  assign rk_valid = r_valid;

endmodule

`default_nettype wire
